// File: rtl/decoder_seq.sv
// decoder_seq: registered ADDR_W-to-2**ADDR_W one-hot decoder with direct and sweep modes.
// Optional DECODER_SEQ_SKIP_ZERO_EN treats index 0 as hardwired $0 (never selected).
module decoder_seq #(
  parameter int ADDR_W = 5,
  parameter int SWEEP_LAST = 2**ADDR_W-1,
  localparam int OUT_W = 2**ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  input  logic              sweep_start,
  input  logic              stall,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);
`ifdef DECODER_SEQ_SKIP_ZERO_EN
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  logic dir_ok;
  assign dir_ok = en && addr != '0;
`else
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(0);
  logic dir_ok;
  assign dir_ok = en;
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SWEEP_LAST);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [OUT_W-1:0] out_nx;
  logic valid_nx, done_nx;
  // DONE holds the last select for a cycle; the done pulse follows as it returns to IDLE
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    out_nx = '0;
    valid_nx = 1'b0;
    done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nx = SWEEP;
          cnt_nx = FIRST;
        end else if (dir_ok) begin
          out_nx = OUT_W'(1) << addr;
          valid_nx = 1'b1;
        end
      end
      SWEEP: begin
        if (!stall) begin
          out_nx = OUT_W'(1) << cnt;
          valid_nx = 1'b1;
          state_nx = cnt == LAST ? DONE : SWEEP;
          cnt_nx = cnt == LAST ? cnt : cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        done_nx = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      out <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      out <= out_nx;
      out_valid <= valid_nx;
      busy <= state_nx == SWEEP;
      done <= done_nx;
    end
  end
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed self-checking bench for decoder_seq (ADDR_W=5).
module tb_decoder_seq;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic en = 1'b0;
  logic sweep_start = 1'b0;
  logic stall = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] out;
  logic out_valid, busy, done;
  int n_chk = 0;
  int n_err = 0;
`ifdef DECODER_SEQ_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  decoder_seq dut (
    .clock(clock), .resetn(resetn), .addr(addr), .en(en),
    .sweep_start(sweep_start), .stall(stall),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out"}, out, 32'h0);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check({tag, "_done"}, {31'b0, done}, 32'h0);
  endtask

  task automatic direct(input logic [4:0] a, input logic [31:0] e);
    en = 1'b1;
    addr = a;
    @(negedge clock);
    en = 1'b0;
    check("dir_out", out, e);
    check("dir_valid", {31'b0, out_valid}, {31'b0, e != 0});
  endtask

  // stall_idx < 0: no stall; otherwise stall 3 edges right after 1<<stall_idx is shown
  task automatic sweep(input int stall_idx, input bit noise);
    int nsel, ps, last_c, p;
    logic [31:0] e;
    nsel = 32 - FIRST;
    ps = stall_idx - FIRST;
    last_c = 1 + nsel + (stall_idx >= 0 ? 3 : 0);
    sweep_start = 1'b1;
    if (noise) begin
      en = 1'b1;
      addr = 5'd4;
    end
    for (int c = 1; c <= last_c + 1; c++) begin
      @(negedge clock);
      sweep_start = 1'b0;
      en = noise ? c[0] : 1'b0;
      addr = c[4:0];
      p = c - 2;
      if (stall_idx >= 0 && p > ps) p = (p <= ps + 3) ? -1 : p - 3;
      e = (p >= 0 && p < nsel) ? 32'd1 << (FIRST + p) : 32'h0;
      check("sw_out", out, e);
      check("sw_valid", {31'b0, out_valid}, {31'b0, e != 0});
      check("sw_busy", {31'b0, busy}, {31'b0, c <= last_c - 1});
      check("sw_done", {31'b0, done}, {31'b0, c == last_c + 1});
      stall = stall_idx >= 0 && c >= ps + 2 && c <= ps + 4;
    end
    en = 1'b0;
    stall = 1'b0;
    direct(5'd5, 32'h20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1;
      addr = 5'(i * 7 + 3);
      sweep_start = i[0];
      @(negedge clock);
      check_idle("rst");
    end
    en = 1'b0;
    sweep_start = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
    check_idle("post_rst");
    direct(5'd13, 32'h0000_2000);
    @(negedge clock);
    check("dir_off_out", out, 32'h0);
    check("dir_off_valid", {31'b0, out_valid}, 32'h0);
    direct(5'd0, FIRST == 1 ? 32'h0 : 32'h1);
    direct(5'd31, 32'h8000_0000);
    @(negedge clock);
    sweep(-1, 1'b0);
    @(negedge clock);
    sweep(6, 1'b0);
    @(negedge clock);
    sweep(-1, 1'b1);
    @(negedge clock);
    // abort a sweep while 1<<10 is on the output
    sweep_start = 1'b1;
    for (int c = 1; c <= 12 - FIRST; c++) begin
      @(negedge clock);
      sweep_start = 1'b0;
    end
    check("abort_pre", out, 32'h400);
    #2 resetn = 1'b0;
    #1 check_idle("abort_now");
    for (int i = 0; i < 3; i++) begin
      en = i[0];
      addr = 5'd9;
      @(negedge clock);
      check_idle("abort_hold");
    end
    en = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
    check_idle("abort_rel");
    direct(5'd3, 32'h8);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
